// File: rtl/reg_pipe_chain.sv
// Elastic register-slice chain: DEPTH valid/ready stages with bubble collapse.
// Optional synchronous flush port enabled by defining PIPE_FLUSH_EN.
module reg_pipe_chain #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    logic              flush_c;
    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  v_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH:0]    rdy_c;
    logic [CNT_W-1:0]  occ_c;

`ifdef PIPE_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // A stage can take a word if it is empty or its own word moves on.
    always_comb begin
        rdy_c        = '0;
        rdy_c[DEPTH] = out_ready && !flush_c;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            rdy_c[i] = !v_q[i] || rdy_c[i+1];
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (rdy_c[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = in_data;
            end
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (rdy_c[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        // Flush drops every word but leaves payload registers as they were.
        if (flush_c) begin
            v_d    = '0;
            data_d = data_q;
        end
    end

    always_comb begin
        occ_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_c = occ_c + CNT_W'(v_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = rdy_c[0] && !flush_c;
    assign out_valid = v_q[DEPTH-1] && !flush_c;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_c;

endmodule
